// File: rtl/sample_delay_line.sv
// Circular sample history for the FIR/equalizer datapath: RAM-backed frame store with
// interleaved-channel staging, tap-addressed registered reads, optional folded read and a zeroing flush.
module sample_delay_line #(
    parameter int DATA_W   = 16,
    parameter int TAPS     = 64,
    parameter int CHANNELS = 1,
    parameter int FOLD     = 0,
    localparam int TAP_W   = $clog2(TAPS),
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int WORD_W  = CHANNELS * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_sample,
    output logic              o_ready,
    output logic              o_frame_done,
    input  logic              i_flush,
    output logic              o_busy,
    input  logic              i_rd_en,
    input  logic [CH_W-1:0]   i_rd_channel,
    input  logic [TAP_W-1:0]  i_rd_tap,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [DATA_W-1:0] o_data_mirror
);
    typedef enum logic {S_FLUSH, S_RUN} state_t;

    localparam logic [TAP_W-1:0] LAST_ADDR = TAP_W'(TAPS - 1);
    localparam logic [TAP_W-1:0] TAP_ONE   = TAP_W'(1);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(CHANNELS - 1);

    state_t             state;
    logic [TAP_W-1:0]   sweep;
    logic [TAP_W-1:0]   wr_ptr;
    logic [CH_W-1:0]    ch_cnt;
    logic               accept;
    logic               commit;
    logic               mem_we;
    logic [TAP_W-1:0]   mem_waddr;
    logic [WORD_W-1:0]  mem_wdata;
    logic [WORD_W-1:0]  commit_word;
    logic [WORD_W-1:0]  mem [TAPS];
    logic [TAP_W-1:0]   rd_addr;
    logic [WORD_W-1:0]  rd_word;
    logic [CH_W-1:0]    rd_ch;
    logic               rd_fire;

    assign o_ready = (state == S_RUN);
    assign o_busy  = (state == S_FLUSH);

    always_comb begin
        accept    = (state == S_RUN) && i_valid && !i_flush;
        commit    = accept && (ch_cnt == LAST_CH);
        mem_we    = (state == S_FLUSH) || commit;
        mem_waddr = (state == S_FLUSH) ? sweep : wr_ptr;
        mem_wdata = (state == S_FLUSH) ? '0 : commit_word;
        rd_addr   = wr_ptr - i_rd_tap - TAP_ONE;
        rd_fire   = (state == S_RUN) && i_rd_en;
    end

    // Channels 0..CHANNELS-2 wait in staging; the last channel completes the word directly.
    if (CHANNELS > 1) begin : g_stage
        logic [(CHANNELS-1)*DATA_W-1:0] staging;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                staging <= '0;
            end else if (state == S_FLUSH) begin
                staging <= '0;
            end else if (accept && !commit) begin
                for (int c = 0; c < CHANNELS - 1; c++) begin
                    if (ch_cnt == CH_W'(c)) staging[c*DATA_W +: DATA_W] <= i_sample;
                end
            end
        end

        assign commit_word = {i_sample, staging};
    end else begin : g_nostage
        assign commit_word = i_sample;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_FLUSH;
            sweep        <= '0;
            wr_ptr       <= '0;
            ch_cnt       <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= commit;
            case (state)
                S_FLUSH: begin
                    if (i_flush) begin
                        sweep <= '0;
                    end else if (sweep == LAST_ADDR) begin
                        state  <= S_RUN;
                        sweep  <= '0;
                        wr_ptr <= '0;
                        ch_cnt <= '0;
                    end else begin
                        sweep <= sweep + TAP_ONE;
                    end
                end
                S_RUN: begin
                    if (i_flush) begin
                        state  <= S_FLUSH;
                        sweep  <= '0;
                        ch_cnt <= '0;
                    end else if (commit) begin
                        wr_ptr <= wr_ptr + TAP_ONE;
                        ch_cnt <= '0;
                    end else if (accept) begin
                        ch_cnt <= ch_cnt + CH_W'(1);
                    end
                end
                default: state <= S_FLUSH;
            endcase
        end
    end

    // NOTE: the storage array has no reset so it maps onto block RAM; the flush sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Reads sample mem before this edge's write lands, giving read-before-write on a commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_valid <= 1'b0;
            rd_word    <= '0;
            rd_ch      <= '0;
        end else begin
            o_rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_word <= mem[rd_addr];
                rd_ch   <= i_rd_channel;
            end
        end
    end

    always_comb begin
        o_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rd_ch == CH_W'(c)) o_data = rd_word[c*DATA_W +: DATA_W];
        end
    end

    if (FOLD != 0) begin : g_fold
        logic [TAP_W-1:0]  mirror_addr;
        logic [WORD_W-1:0] rd_word_m;

        assign mirror_addr = wr_ptr + i_rd_tap;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_word_m <= '0;
            end else if (rd_fire) begin
                rd_word_m <= mem[mirror_addr];
            end
        end

        always_comb begin
            o_data_mirror = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (rd_ch == CH_W'(c)) o_data_mirror = rd_word_m[c*DATA_W +: DATA_W];
            end
        end
    end else begin : g_nofold
        assign o_data_mirror = '0;
    end
endmodule

// File: tb/tb_sample_delay_line.sv
// Bench for sample_delay_line: two instances (64 taps mono folded, 8 taps stereo) against
// a frame-log reference model, with directed scenarios followed by randomized traffic.
module tb_sample_delay_line;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        valid [2];
    logic [15:0] samp  [2];
    logic        flush [2];
    logic        re    [2];
    logic        rch   [2];
    logic [5:0]  rtap  [2];

    logic        rdy   [2];
    logic        fd    [2];
    logic        bsy   [2];
    logic        rv    [2];
    logic [15:0] dat   [2];
    logic [15:0] mir   [2];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: every committed frame since the last flush, oldest first.
    logic [31:0] flog [2][0:4095];
    int          n_frames [2];
    int          busy_left [2];
    int          part_cnt [2];
    logic [15:0] part_smp [2];
    logic [15:0] exp_d [2];
    logic [15:0] exp_m [2];
    logic        exp_rv [2];
    logic        exp_fd [2];
    int          fd_seen;

    always #5 clk = ~clk;

    sample_delay_line #(.DATA_W(16), .TAPS(64), .CHANNELS(1), .FOLD(1)) dut_a (
        .clk(clk), .rst(rst),
        .i_valid(valid[0]), .i_sample(samp[0]), .o_ready(rdy[0]), .o_frame_done(fd[0]),
        .i_flush(flush[0]), .o_busy(bsy[0]),
        .i_rd_en(re[0]), .i_rd_channel(rch[0]), .i_rd_tap(rtap[0]),
        .o_rd_valid(rv[0]), .o_data(dat[0]), .o_data_mirror(mir[0])
    );

    sample_delay_line #(.DATA_W(16), .TAPS(8), .CHANNELS(2), .FOLD(0)) dut_b (
        .clk(clk), .rst(rst),
        .i_valid(valid[1]), .i_sample(samp[1]), .o_ready(rdy[1]), .o_frame_done(fd[1]),
        .i_flush(flush[1]), .o_busy(bsy[1]),
        .i_rd_en(re[1]), .i_rd_channel(rch[1]), .i_rd_tap(rtap[1][2:0]),
        .o_rd_valid(rv[1]), .o_data(dat[1]), .o_data_mirror(mir[1])
    );

    function automatic int taps_of(input int d);
        return (d == 0) ? 64 : 8;
    endfunction

    function automatic int chans_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic logic [15:0] model_read(input int d, input int age, input logic ch);
        logic [31:0] w;
        if (int'(ch) >= chans_of(d) || age >= n_frames[d]) return 16'h0;
        w = flog[d][n_frames[d] - 1 - age];
        return ch ? w[31:16] : w[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            n_frames[d]  = 0;
            busy_left[d] = taps_of(d);
            part_cnt[d]  = 0;
            part_smp[d]  = '0;
            exp_d[d]     = '0;
            exp_m[d]     = '0;
            exp_rv[d]    = 1'b0;
            exp_fd[d]    = 1'b0;
        end
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            valid[d] = 1'b0;
            samp[d]  = '0;
            flush[d] = 1'b0;
            re[d]    = 1'b0;
            rch[d]   = 1'b0;
            rtap[d]  = '0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_ready%0d", tag, d), 32'(rdy[d]), 32'(busy_left[d] == 0));
            check($sformatf("%s_busy%0d", tag, d), 32'(bsy[d]), 32'(busy_left[d] != 0));
            check($sformatf("%s_fdone%0d", tag, d), 32'(fd[d]), 32'(exp_fd[d]));
            check($sformatf("%s_rdval%0d", tag, d), 32'(rv[d]), 32'(exp_rv[d]));
            check($sformatf("%s_data%0d", tag, d), 32'(dat[d]), 32'(exp_d[d]));
            check($sformatf("%s_mirror%0d", tag, d), 32'(mir[d]), 32'(exp_m[d]));
        end
    endtask

    // One clock: predict reads from the pre-edge history, advance the model, compare.
    task automatic step();
        logic acc [2];
        for (int d = 0; d < 2; d++) begin
            exp_rv[d] = (busy_left[d] == 0) && re[d];
            if (exp_rv[d]) begin
                exp_d[d] = model_read(d, int'(rtap[d]), rch[d]);
                exp_m[d] = (d == 0) ? model_read(d, taps_of(d) - 1 - int'(rtap[d]), rch[d]) : 16'h0;
            end
            acc[d] = (busy_left[d] == 0) && valid[d] && !flush[d];
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_fd[d] = 1'b0;
            if (busy_left[d] > 0) begin
                busy_left[d] = flush[d] ? taps_of(d) : busy_left[d] - 1;
            end else if (flush[d]) begin
                busy_left[d] = taps_of(d);
                n_frames[d]  = 0;
                part_cnt[d]  = 0;
            end else if (acc[d]) begin
                if (part_cnt[d] < chans_of(d) - 1) begin
                    part_smp[d] = samp[d];
                    part_cnt[d]++;
                end else begin
                    flog[d][n_frames[d]] = (chans_of(d) == 1) ? {16'h0, samp[d]} : {samp[d], part_smp[d]};
                    n_frames[d]++;
                    part_cnt[d] = 0;
                    exp_fd[d]   = 1'b1;
                end
            end
        end
        if (fd[0]) fd_seen++;
        check_all("cyc");
    endtask

    task automatic read_tap(input int d, input int t, input logic ch);
        re[d]   = 1'b1;
        rtap[d] = 6'(t);
        rch[d]  = ch;
    endtask

    initial begin
        int k;
        int busy_cycles;
        idle();
        model_reset();
        fd_seen = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Flush after reset, reads are ignored until each instance turns ready.
        for (int i = 0; i < 66; i++) begin
            read_tap(0, int'($urandom_range(0, 63)), 1'b0);
            read_tap(1, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            step();
        end
        for (int t = 0; t < 64; t++) begin
            read_tap(0, t, 1'b0);
            read_tap(1, t % 8, 1'(t / 8));
            step();
        end
        idle();
        step();

        // Ordering on the mono instance, stereo pairs on the other.
        fd_seen = 0;
        for (int i = 1; i <= 64; i++) begin
            idle();
            valid[0] = 1'b1;
            samp[0]  = 16'(i);
            if (i <= 20) begin
                k        = (i + 1) / 2;
                valid[1] = 1'b1;
                samp[1]  = (i % 2 == 1) ? 16'(10 * k) : 16'(-10 * k);
            end
            step();
        end
        idle();
        read_tap(0, 5, 1'b0);
        read_tap(1, 0, 1'b1);
        step();
        check("fold_data", 32'(dat[0]), 32'd59);
        check("fold_mirror", 32'(mir[0]), 32'd6);
        check("mc_ch1_tap0", 32'(dat[1]), 32'(16'hFF9C));
        idle();
        read_tap(1, 7, 1'b0);
        valid[1] = 1'b1;
        samp[1]  = 16'd110;
        step();
        check("mc_ch0_tap7", 32'(dat[1]), 32'd30);
        idle();
        read_tap(1, 0, 1'b0);
        step();
        check("mc_partial_hidden", 32'(dat[1]), 32'd100);

        // Commit frame 65 while reading the oldest tap.
        idle();
        valid[0] = 1'b1;
        samp[0]  = 16'd65;
        read_tap(0, 63, 1'b0);
        step();
        check("coll_same", 32'(dat[0]), 32'd1);
        idle();
        read_tap(0, 63, 1'b0);
        step();
        check("coll_next63", 32'(dat[0]), 32'd2);
        read_tap(0, 0, 1'b0);
        step();
        check("coll_next0", 32'(dat[0]), 32'd65);
        for (int i = 66; i <= 70; i++) begin
            idle();
            valid[0] = 1'b1;
            samp[0]  = 16'(i);
            step();
        end
        idle();
        read_tap(0, 0, 1'b0);
        step();
        check("ord_tap0", 32'(dat[0]), 32'd70);
        read_tap(0, 63, 1'b0);
        step();
        check("ord_tap63", 32'(dat[0]), 32'd7);
        check("ord_fdone_count", 32'(fd_seen), 32'd70);

        // Flush with a half-written frame in the stereo instance.
        idle();
        flush[1] = 1'b1;
        valid[1] = 1'b1;
        samp[1]  = 16'd999;
        step();
        idle();
        busy_cycles = 0;
        for (int i = 0; i < 20 && !rdy[1]; i++) begin
            busy_cycles++;
            step();
        end
        check("flush_len", 32'(busy_cycles), 32'd8);
        for (int t = 0; t < 16; t++) begin
            read_tap(1, t % 8, 1'(t / 8));
            step();
            check("flush_zero", 32'(dat[1]), 32'd0);
        end
        idle();
        valid[1] = 1'b1;
        samp[1]  = 16'd7;
        step();
        samp[1]  = 16'hFFF9;
        step();
        idle();
        read_tap(1, 0, 1'b0);
        step();
        check("post_flush_ch0", 32'(dat[1]), 32'd7);
        read_tap(1, 0, 1'b1);
        step();
        check("post_flush_ch1", 32'(dat[1]), 32'(16'hFFF9));

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 2; d++) begin
                valid[d] = ($urandom_range(0, 3) != 0);
                samp[d]  = 16'($urandom);
                flush[d] = ($urandom_range(0, 120) == 0);
                re[d]    = ($urandom_range(0, 2) != 0);
                rch[d]   = 1'($urandom_range(0, 1));
                rtap[d]  = 6'($urandom_range(0, taps_of(d) - 1));
            end
            step();
        end

        // Asynchronous reset in the middle of traffic.
        idle();
        rst = 1'b1;
        #1;
        model_reset();
        check_all("midrst");
        #1;
        rst = 1'b0;
        for (int i = 0; i < 90; i++) begin
            read_tap(0, int'($urandom_range(0, 63)), 1'b0);
            read_tap(1, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            valid[1] = 1'b1;
            samp[1]  = 16'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
